wishbone_bus_if: RTL and testbench

- Bridge between the core's SRAM-style memory port (ram_*/rom_* outputs of the CPU top) and an external Wishbone B3 classic-cycle bus.
- Sits directly downstream of the CPU top; one instance serves instruction fetch, one serves data.
- Converts single-cycle CPU requests into multi-cycle Wishbone transfers.
- Holds the pipeline via stallreq_o and buffers read data until the pipeline releases.

---
 rtl/wishbone_bus_if.sv | 172 +++++++++++++++++
 tb/tb_wishbone_bus_if.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_if.sv
// ============================================================================
// wishbone_bus_if : SRAM-style CPU port to Wishbone B3 classic-cycle bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module wishbone_bus_if #(
   parameter int STALL_BIT = 1,
   parameter int TIMEOUT   = 255,
   parameter int CNT_W     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   input  logic        cpu_ce_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_we_i,
   input  logic [3:0]  cpu_sel_i,
   output logic [31:0] cpu_data_o,
   output logic        stallreq_o,
   output logic        bus_err_o,
   input  logic [31:0] wishbone_data_i,
   input  logic        wishbone_ack_i,
   output logic [31:0] wishbone_addr_o,
   output logic [31:0] wishbone_data_o,
   output logic        wishbone_we_o,
   output logic [3:0]  wishbone_sel_o,
   output logic        wishbone_stb_o,
   output logic        wishbone_cyc_o
);

   typedef enum logic [1:0] {
      IDLE           = 2'b00,
      BUSY           = 2'b01,
      WAIT_FOR_STALL = 2'b10
   } state_e;

   // Last counter value before abort; unused when the timeout is disabled.
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

   state_e            state_q;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [3:0]        sel_q;
   logic              stb_q;
   logic              cyc_q;
   logic [31:0]       rd_buf_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              err_q;

   logic              stall_bit;
   logic              timeout_hit;
   logic              unused_stall;

   assign stall_bit    = stall_i[STALL_BIT];
   assign unused_stall = ^stall_i;
   assign cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
   assign timeout_hit  = (TIMEOUT != 0) && (state_q == BUSY) && !flush_i
                         && !wishbone_ack_i && (cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         sel_q    <= '0;
         stb_q    <= 1'b0;
         cyc_q    <= 1'b0;
         rd_buf_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_ce_i && !flush_i) begin
                  addr_q  <= cpu_addr_i;
                  wdata_q <= cpu_data_i;
                  we_q    <= cpu_we_i;
                  sel_q   <= cpu_sel_i;
                  stb_q   <= 1'b1;
                  cyc_q   <= 1'b1;
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               // Flush wins over a same-cycle ack; the returned data is dropped.
               if (flush_i) begin
                  addr_q   <= '0;
                  wdata_q  <= '0;
                  we_q     <= 1'b0;
                  sel_q    <= '0;
                  stb_q    <= 1'b0;
                  cyc_q    <= 1'b0;
                  rd_buf_q <= '0;
                  state_q  <= IDLE;
               end else if (wishbone_ack_i) begin
                  addr_q  <= '0;
                  wdata_q <= '0;
                  we_q    <= 1'b0;
                  sel_q   <= '0;
                  stb_q   <= 1'b0;
                  cyc_q   <= 1'b0;
                  if (!we_q) begin
                     rd_buf_q <= wishbone_data_i;
                  end
                  state_q <= stall_bit ? WAIT_FOR_STALL : IDLE;
               end else if (timeout_hit) begin
                  addr_q   <= '0;
                  wdata_q  <= '0;
                  we_q     <= 1'b0;
                  sel_q    <= '0;
                  stb_q    <= 1'b0;
                  cyc_q    <= 1'b0;
                  rd_buf_q <= '0;
                  err_q    <= 1'b1;
                  state_q  <= stall_bit ? WAIT_FOR_STALL : IDLE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            WAIT_FOR_STALL: begin
               if (flush_i) begin
                  rd_buf_q <= '0;
                  state_q  <= IDLE;
               end else if (!stall_bit) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      stallreq_o = 1'b0;
      cpu_data_o = '0;
      if (!rst) begin
         case (state_q)
            IDLE: stallreq_o = cpu_ce_i & ~flush_i;
            BUSY: begin
               if (wishbone_ack_i && !flush_i) begin
                  if (!we_q) begin
                     cpu_data_o = wishbone_data_i;
                  end
               end else begin
                  stallreq_o = !timeout_hit;
               end
            end
            WAIT_FOR_STALL: cpu_data_o = rd_buf_q;
            default: ;
         endcase
      end
   end

   assign wishbone_addr_o = addr_q;
   assign wishbone_data_o = wdata_q;
   assign wishbone_we_o   = we_q;
   assign wishbone_sel_o  = sel_q;
   assign wishbone_stb_o  = stb_q;
   assign wishbone_cyc_o  = cyc_q;
   assign bus_err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_wishbone_bus_if.sv
// ============================================================================
// tb_wishbone_bus_if : scoreboard bench for the Wishbone bridge
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_wishbone_bus_if;

   localparam int SB = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] cpu_rdata;
   logic        stallreq;
   logic        bus_err;
   logic [31:0] wb_di;
   logic        wb_ack;
   logic [31:0] wb_addr;
   logic [31:0] wb_do;
   logic        wb_we;
   logic [3:0]  wb_sel;
   logic        wb_stb;
   logic        wb_cyc;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mdl_rdbuf;

   always #5 clk = ~clk;

   wishbone_bus_if #(
      .STALL_BIT (SB),
      .TIMEOUT   (4),
      .CNT_W     (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall),
      .flush_i         (flush),
      .cpu_ce_i        (ce),
      .cpu_addr_i      (addr),
      .cpu_data_i      (wdata),
      .cpu_we_i        (we),
      .cpu_sel_i       (sel),
      .cpu_data_o      (cpu_rdata),
      .stallreq_o      (stallreq),
      .bus_err_o       (bus_err),
      .wishbone_data_i (wb_di),
      .wishbone_ack_i  (wb_ack),
      .wishbone_addr_o (wb_addr),
      .wishbone_data_o (wb_do),
      .wishbone_we_o   (wb_we),
      .wishbone_sel_o  (wb_sel),
      .wishbone_stb_o  (wb_stb),
      .wishbone_cyc_o  (wb_cyc)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      #1;
      check({tag, "_stb"}, {31'b0, wb_stb}, 32'd0);
      check({tag, "_cyc"}, {31'b0, wb_cyc}, 32'd0);
      check({tag, "_addr"}, wb_addr, 32'd0);
      check({tag, "_stallreq"}, {31'b0, stallreq}, 32'd0);
      check({tag, "_rdata"}, cpu_rdata, 32'd0);
   endtask

   // One CPU access: waits = BUSY cycles before the ack cycle, hold = extra
   // cycles the watched stall bit stays high after the ack.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int waits, input logic [31:0] rd,
                       input int hold);
      logic [31:0] cur;
      logic [31:0] wait_exp;
      ce = 1'b1; we = w; addr = a; wdata = d; sel = s;
      #1;
      check("req_stallreq", {31'b0, stallreq}, 32'd1);
      check("req_stb", {31'b0, wb_stb}, 32'd0);
      exp_q.push_back(w ? 32'd0 : rd);
      if (!w) mdl_rdbuf = rd;
      wait_exp = mdl_rdbuf;
      step();
      ce = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < waits; i++) begin
         wb_ack = 1'b0;
         #1;
         check("busy_stb", {30'b0, wb_stb, wb_cyc}, 32'd3);
         check("busy_addr", wb_addr, a);
         check("busy_wdata", wb_do, d);
         check("busy_we_sel", {27'b0, wb_we, wb_sel}, {27'b0, w, s});
         check("busy_stallreq", {31'b0, stallreq}, 32'd1);
         check("busy_rdata", cpu_rdata, 32'd0);
         step();
      end
      wb_ack = 1'b1; wb_di = rd;
      stall[SB] = (hold > 0);
      #1;
      cur = exp_q.pop_front();
      check("ack_stb", {31'b0, wb_stb}, 32'd1);
      check("ack_we", {31'b0, wb_we}, {31'b0, w});
      check("ack_stallreq", {31'b0, stallreq}, 32'd0);
      check("ack_rdata", cpu_rdata, cur);
      step();
      wb_ack = 1'b0; wb_di = 32'h5555_AAAA;
      if (hold > 0) begin
         for (int h = 0; h <= hold; h++) begin
            stall[SB] = (h < hold);
            #1;
            check("wait_rdata", cpu_rdata, wait_exp);
            check("wait_stallreq", {31'b0, stallreq}, 32'd0);
            check("wait_stb", {31'b0, wb_stb}, 32'd0);
            step();
         end
      end
      stall = '0;
      check_idle("post");
   endtask

   initial begin
      rst = 1'b1; stall = '0; flush = 1'b0; ce = 1'b1; addr = 32'h40;
      wdata = '0; we = 1'b0; sel = 4'hF; wb_di = '0; wb_ack = 1'b0;
      mdl_rdbuf = '0;
      @(negedge clk);
      step();
      check_idle("rst");
      rst = 1'b0; ce = 1'b0;
      step();

      xfer(1'b0, 32'h10, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, 0);
      xfer(1'b0, 32'h14, 32'h0, 4'hF, 0, 32'hA5A5_A5A5, 4);
      xfer(1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1, 32'h0BAD_0BAD, 2);

      // Flush in the second BUSY cycle together with an ack.
      ce = 1'b1; addr = 32'h30; we = 1'b0; sel = 4'hF;
      step();
      ce = 1'b0;
      step();
      flush = 1'b1; wb_ack = 1'b1; wb_di = 32'h1111_1111;
      #1;
      check("flush_rdata", cpu_rdata, 32'd0);
      check("flush_stallreq", {31'b0, stallreq}, 32'd1);
      step();
      flush = 1'b0; wb_ack = 1'b0;
      check_idle("flush");
      mdl_rdbuf = '0;
      xfer(1'b1, 32'h24, 32'hCAFE_0001, 4'hF, 0, 32'h0, 1);

      // Request masked by flush in IDLE.
      ce = 1'b1; flush = 1'b1;
      #1;
      check("ceflush_stallreq", {31'b0, stallreq}, 32'd0);
      step();
      ce = 1'b0; flush = 1'b0;
      check_idle("ceflush");

      // Timeout: read with no ack, abort in the fourth BUSY cycle.
      xfer(1'b0, 32'h44, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 0);
      ce = 1'b1; addr = 32'h50;
      step();
      ce = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("to_stb", {31'b0, wb_stb}, 32'd1);
         check("to_stallreq", {31'b0, stallreq}, (i < 3) ? 32'd1 : 32'd0);
         check("to_err_early", {31'b0, bus_err}, 32'd0);
         check("to_rdata", cpu_rdata, 32'd0);
         step();
      end
      #1;
      check("to_err", {31'b0, bus_err}, 32'd1);
      check_idle("to");
      step();
      #1;
      check("to_err_once", {31'b0, bus_err}, 32'd0);
      mdl_rdbuf = '0;
      xfer(1'b1, 32'h28, 32'h0, 4'hF, 0, 32'h0, 1);

      // Reset during BUSY; a late ack must be ignored.
      ce = 1'b1; addr = 32'h60;
      step();
      ce = 1'b0; rst = 1'b1;
      #1;
      check("rstbusy_stallreq", {31'b0, stallreq}, 32'd0);
      check("rstbusy_rdata", cpu_rdata, 32'd0);
      step();
      rst = 1'b0; wb_ack = 1'b1; wb_di = 32'h7777_7777;
      check_idle("rst_late_ack");
      check("rst_we_sel", {27'b0, wb_we, wb_sel}, 32'd0);
      step();
      wb_ack = 1'b0;
      check_idle("rst_after");

      check("sb_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
